// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder stage per clock, LSB first,
// with a registered result, carry-out and two's-complement overflow flag.
module serial_addsub #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-2:0] res_sh_q, res_sh_d;
   logic             carry_q, carry_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             bit_s;
   logic             bit_c;
   logic [WIDTH-1:0] res_full;

   function automatic logic fa_sum(input logic x, input logic y, input logic c);
      return x ^ y ^ c;
   endfunction

   function automatic logic fa_carry(input logic x, input logic y, input logic c);
      return (x & y) | (x & c) | (y & c);
   endfunction

   always_comb begin
      bit_s    = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
      bit_c    = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
      // The result register keeps WIDTH-1 bits; the final bit is the one being produced now.
      res_full = {bit_s, res_sh_q};
   end

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            res_sh_d = res_full[WIDTH-1:1];
            carry_d  = bit_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               sum_d   = res_full;
               cout_d  = bit_c;
               // carry_q is the carry into the MSB on this last stage
               ovf_d   = carry_q ^ bit_c;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random bench for serial_addsub (WIDTH=6), compared against an
// arithmetic model of unsigned/signed add and subtract.
module tb_serial_addsub;

   localparam int W = 6;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] prev_sum  = '0;
   logic         prev_cout = 1'b0;
   logic         prev_ovf  = 1'b0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sub  (sub),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Arithmetic model: plain integer add/subtract, signed range test for overflow.
   task automatic model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, output logic [W-1:0] es, output logic ec,
                        output logic eo);
      int ux, uy, sx, sy, ur, sr;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 32) ? ux - 64 : ux;
      sy = (uy >= 32) ? uy - 64 : uy;
      if (s) begin
         ur = ux - uy;
         sr = sx - sy;
         ec = (ux >= uy);
      end else begin
         ur = ux + uy + int'(c);
         sr = sx + sy + int'(c);
         ec = (ur > 63);
      end
      es = W'((ur + 128) % 64);
      eo = (sr > 31) || (sr < -32);
   endtask

   // One operation. inj: RUN cycle at which a spurious start is pulsed (0 = none).
   // rst_at: RUN cycle at which reset is asserted (0 = none).
   task automatic op(input string tag, input logic s, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic c, input int inj, input int rst_at);
      logic [W-1:0] es;
      logic         ec, eo;
      model(s, x, y, c, es, ec, eo);
      start = 1'b1; sub = s; a = x; b = y; cin = c;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= W; i++) begin
         chk({tag, " busy_run"}, busy, 1'b1);
         chk({tag, " done_run"}, done, 1'b0);
         chk({tag, " sum_hold"}, sum, prev_sum);
         if (i == 1) begin
            chk({tag, " cout_hold"}, cout, prev_cout);
            chk({tag, " ovf_hold"}, ovf, prev_ovf);
         end
         if (i == inj) begin
            start = 1'b1; sub = ~s; a = ~x; b = x; cin = ~c;
         end else begin
            start = 1'b0;
         end
         if (i == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk({tag, " rst_busy"}, busy, 1'b0);
            chk({tag, " rst_done"}, done, 1'b0);
            chk({tag, " rst_sum"}, sum, '0);
            chk({tag, " rst_cout"}, cout, 1'b0);
            chk({tag, " rst_ovf"}, ovf, 1'b0);
            repeat (3) begin
               @(posedge clk); #1;
               chk({tag, " rst_hold_done"}, done, 1'b0);
            end
            rst_n = 1'b1;
            prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
            for (int k = 0; k < W + 2; k++) begin
               @(posedge clk); #1;
               chk({tag, " after_rst_done"}, done, 1'b0);
               chk({tag, " after_rst_busy"}, busy, 1'b0);
            end
            return;
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk({tag, " done"}, done, 1'b1);
      chk({tag, " busy_done"}, busy, 1'b0);
      chk({tag, " sum"}, sum, es);
      chk({tag, " cout"}, cout, ec);
      chk({tag, " ovf"}, ovf, eo);
      prev_sum = es; prev_cout = ec; prev_ovf = eo;
      @(posedge clk); #1;
      chk({tag, " done_gone"}, done, 1'b0);
      chk({tag, " busy_idle"}, busy, 1'b0);
      chk({tag, " sum_idle"}, sum, es);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      #3;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_sum", sum, '0);
      chk("reset_cout", cout, 1'b0);
      chk("reset_ovf", ovf, 1'b0);
      #20;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_no_start", busy, 1'b0);

      op("add_0_0", 1'b0, 6'd0, 6'd0, 1'b0, 0, 0);
      op("add_63_1", 1'b0, 6'd63, 6'd1, 1'b0, 0, 0);
      op("add_63_63_c", 1'b0, 6'd63, 6'd63, 1'b1, 0, 0);
      op("add_31_1", 1'b0, 6'd31, 6'd1, 1'b0, 0, 0);
      op("sub_5_7", 1'b1, 6'd5, 6'd7, 1'b0, 0, 0);
      op("sub_7_5", 1'b1, 6'd7, 6'd5, 1'b1, 0, 0);
      op("sub_32_1", 1'b1, 6'd32, 6'd1, 1'b0, 0, 0);
      op("start_in_run", 1'b0, 6'd12, 6'd9, 1'b1, 3, 0);
      op("rst_in_run", 1'b0, 6'd40, 6'd30, 1'b0, 0, 4);
      op("add_after_rst", 1'b0, 6'd1, 6'd2, 1'b0, 0, 0);

      for (int n = 0; n < 24; n++) begin
         op("rand", 1'(($urandom) & 1), W'($urandom), W'($urandom), 1'(($urandom) & 1),
            0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
